// File: rtl/add3_seq_ctrl.sv
// add3_seq_ctrl: performs a 3*NSLICE-bit unsigned add by time-multiplexing one
// external combinational 3-bit adder slice (a[2:0] + b[2:0] -> r[3:0]).
// Latency: done pulses NSLICE+K cycles after the start acceptance edge, where
//   K (0..NSLICE-1) is the number of extra passes needed to add in a pending carry.
// Handshake: start is only sampled in IDLE; it is ignored while busy or in DONE.
//
// Ports:
//   clk, rst_n    - clock (rising edge), async active-low reset
//   start         - request, accepted only in IDLE
//   op_a, op_b    - operands, latched on acceptance
//   busy, done    - busy in ADD/CARRY; done is a one-cycle result-valid pulse
//   sum           - registered result, MSB is the final carry
//   add_a, add_b  - operands driven to the shared adder
//   add_r         - adder result (combinational, same cycle)
module add3_seq_ctrl #(
  parameter int NSLICE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3*NSLICE-1:0] op_a,
  input  logic [3*NSLICE-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [3*NSLICE:0]   sum,
  output logic [2:0]          add_a,
  output logic [2:0]          add_b,
  input  logic [3:0]          add_r
);

  localparam int W  = 3 * NSLICE;
  localparam int SW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SW-1:0] LAST = SW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_CARRY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  slice_q, slice_d;
  logic           carry_q, carry_d;
  logic           c1_q, c1_d;
  logic [2:0]     partial_q, partial_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     sum_q, sum_d;
  logic           advance;
  logic [2:0]     a_slice, b_slice;

  assign a_slice = a_q[3*slice_q +: 3];
  assign b_slice = b_q[3*slice_q +: 3];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      slice_q   <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      partial_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      slice_q   <= slice_d;
      carry_q   <= carry_d;
      c1_q      <= c1_d;
      partial_q <= partial_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    slice_d   = slice_q;
    carry_d   = carry_q;
    c1_d      = c1_q;
    partial_d = partial_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sum_d   = '0;
          slice_d = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (!carry_q) begin
          sum_d[3*slice_q +: 3] = add_r[2:0];
          carry_d = add_r[3];
          advance = 1'b1;
        end else begin
          // Pending carry: keep the raw slice sum and add the carry next cycle.
          partial_d = add_r[2:0];
          c1_d      = add_r[3];
          state_d   = S_CARRY;
        end
      end
      S_CARRY: begin
        sum_d[3*slice_q +: 3] = add_r[2:0];
        // c1 and the carry out of partial+1 are mutually exclusive.
        carry_d = c1_q | add_r[3];
        advance = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (slice_q == LAST) begin
        sum_d[W] = carry_d;
        state_d  = S_DONE;
      end else begin
        slice_d = slice_q + SW'(1);
        state_d = S_ADD;
      end
    end
  end

  // Outputs decoded from registered state only (no path from add_r).
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    add_a = 3'b000;
    add_b = 3'b000;
    case (state_q)
      S_ADD: begin
        busy  = 1'b1;
        add_a = a_slice;
        add_b = b_slice;
      end
      S_CARRY: begin
        busy  = 1'b1;
        add_a = partial_q;
        add_b = 3'b001;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_add3_seq_ctrl.sv
module tb_add3_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance, NSLICE=4
  logic        start;
  logic [11:0] op_a, op_b;
  logic        busy, done;
  logic [12:0] sum;
  logic [2:0]  add_a, add_b;
  logic [3:0]  add_r;
  assign add_r = {1'b0, add_a} + {1'b0, add_b};

  add3_seq_ctrl #(.NSLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .add_a(add_a), .add_b(add_b), .add_r(add_r)
  );

  // Extra instances, NSLICE=1 and NSLICE=6, driven together
  logic        start_x;
  logic [17:0] opx_a, opx_b;
  logic        busy1, done1, busy6, done6;
  logic [3:0]  sum1;
  logic [18:0] sum6;
  logic [2:0]  a1, b1, a6, b6;
  logic [3:0]  r1, r6;
  assign r1 = {1'b0, a1} + {1'b0, b1};
  assign r6 = {1'b0, a6} + {1'b0, b6};

  add3_seq_ctrl #(.NSLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .op_a(opx_a[2:0]), .op_b(opx_b[2:0]),
    .busy(busy1), .done(done1), .sum(sum1), .add_a(a1), .add_b(b1), .add_r(r1)
  );

  add3_seq_ctrl #(.NSLICE(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .op_a(opx_a), .op_b(opx_b),
    .busy(busy6), .done(done6), .sum(sum6), .add_a(a6), .add_b(b6), .add_r(r6)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain addition; K counts slices i>=1 that receive a carry
  // from the sum of the lower 3*i bits.
  function automatic void model(input int n, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] s, output int k);
    logic [63:0] m;
    s = a + b;
    k = 0;
    for (int i = 1; i < n; i++) begin
      m = (64'd1 << (3 * i)) - 64'd1;
      if ((((a & m) + (b & m)) >> (3 * i)) != 64'd0) k++;
    end
  endfunction

  logic [5:0] pairs[$];

  task automatic run4(input logic [11:0] a, input logic [11:0] b,
                      output logic [12:0] s, output int lat);
    pairs.delete();
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) pairs.push_back({add_a, add_b});
      @(posedge clk); #1;
      lat++;
    end
    s = sum;
    if (done !== 1'b1) begin
      checks++; errs++;
      $display("FAIL timeout4: done not seen after %0d cycles, required within 8", lat);
    end
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("done_single_pulse", {63'd0, done}, 64'd0);
    chk("sum_hold", {51'd0, sum}, {51'd0, s});
  endtask

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [12:0] s;
    int          k;
  } vec_t;

  vec_t        vt[8];
  logic [5:0]  seq_max[7];
  logic [5:0]  seq_nc[4];
  logic [12:0] s4;
  int          lat4;
  logic [63:0] ms;
  int          mk;

  localparam int M = 60;
  logic [11:0] ha[M], hb[M];
  logic        hflag[M];
  logic [12:0] hsum[M];

  logic [3:0]  xs1;
  logic [18:0] xs6;
  int          l1, l6, p1, p6;
  logic [63:0] ea, eb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{12'h001, 12'h003, 13'h0004, 0};
    vt[1] = '{12'hFFF, 12'h001, 13'h1000, 3};
    vt[2] = '{12'hFFF, 12'hFFF, 13'h1FFE, 3};
    vt[3] = '{12'h123, 12'h456, 13'h0579, 1};
    vt[4] = '{12'h007, 12'h001, 13'h0008, 1};
    vt[5] = '{12'h800, 12'h800, 13'h1000, 0};
    vt[6] = '{12'h000, 12'h000, 13'h0000, 0};
    vt[7] = '{12'hE00, 12'h3FF, 13'h11FF, 0};
    seq_max = '{6'o77, 6'o77, 6'o61, 6'o77, 6'o61, 6'o77, 6'o61};
    seq_nc  = '{6'o13, 6'o00, 6'o00, 6'o00};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    start_x = 1'b0; opx_a = '0; opx_b = '0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", {51'd0, sum}, 64'd0);
    chk("rst_add_a", {61'd0, add_a}, 64'd0);
    chk("rst_add_b", {61'd0, add_b}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset mid-operation
    @(negedge clk); op_a = 12'h123; op_b = 12'h456; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_sum", {51'd0, sum}, 64'd0);
    chk("arst_add_a", {61'd0, add_a}, 64'd0);
    chk("arst_add_b", {61'd0, add_b}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", {63'd0, done}, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {63'd0, busy}, 64'd0);

    // Directed vectors
    for (int v = 0; v < 8; v++) begin
      run4(vt[v].a, vt[v].b, s4, lat4);
      chk($sformatf("vec%0d_sum", v), {51'd0, s4}, {51'd0, vt[v].s});
      chk($sformatf("vec%0d_lat", v), 64'(lat4), 64'(4 + vt[v].k));
      if (v == 0) begin
        chk("nocarry_seq_len", 64'(pairs.size()), 64'd4);
        for (int i = 0; i < 4 && i < pairs.size(); i++)
          chk($sformatf("nocarry_seq%0d", i), {58'd0, pairs[i]}, {58'd0, seq_nc[i]});
      end
      if (v == 2) begin
        chk("max_seq_len", 64'(pairs.size()), 64'd7);
        for (int i = 0; i < 7 && i < pairs.size(); i++)
          chk($sformatf("max_seq%0d", i), {58'd0, pairs[i]}, {58'd0, seq_max[i]});
      end
    end

    // Handshake: start held high with operands changing every cycle
    for (int c = 0; c < M; c++) begin
      ha[c] = 12'($urandom); hb[c] = 12'($urandom);
      hflag[c] = 1'b0; hsum[c] = '0;
    end
    begin
      int acc;
      acc = 0;
      while (acc < M) begin
        model(4, {52'd0, ha[acc]}, {52'd0, hb[acc]}, ms, mk);
        if (acc + 4 + mk < M) begin
          hflag[acc + 4 + mk] = 1'b1;
          hsum[acc + 4 + mk] = ms[12:0];
        end
        acc = acc + 4 + mk + 2;
      end
    end
    for (int c = 0; c < M; c++) begin
      @(negedge clk);
      start = 1'b1; op_a = ha[c]; op_b = hb[c];
      @(posedge clk); #1;
      chk($sformatf("hs_done_c%0d", c), {63'd0, done}, {63'd0, hflag[c]});
      if (hflag[c]) chk($sformatf("hs_sum_c%0d", c), {51'd0, sum}, {51'd0, hsum[c]});
      if (done === 1'b1) chk("hs_busy_excl", {63'd0, busy}, 64'd0);
    end
    @(negedge clk); start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Random, NSLICE=4
    for (int i = 0; i < 1000; i++) begin
      ea = {52'd0, 12'($urandom)}; eb = {52'd0, 12'($urandom)};
      model(4, ea, eb, ms, mk);
      run4(ea[11:0], eb[11:0], s4, lat4);
      chk("rnd4_sum", {51'd0, s4}, {51'd0, ms[12:0]});
      chk("rnd4_lat", 64'(lat4), 64'(4 + mk));
    end

    // Random, NSLICE=1 and NSLICE=6 in parallel
    for (int i = 0; i < 300; i++) begin
      ea = {46'd0, 18'($urandom)}; eb = {46'd0, 18'($urandom)};
      @(negedge clk);
      opx_a = ea[17:0]; opx_b = eb[17:0]; start_x = 1'b1;
      @(posedge clk); #1;
      start_x = 1'b0;
      l1 = -1; l6 = -1; p1 = 0; p6 = 0; xs1 = '0; xs6 = '0;
      for (int n = 0; n < 16; n++) begin
        if (done1 === 1'b1) begin
          p1++;
          if (l1 < 0) begin l1 = n; xs1 = sum1; end
        end
        if (done6 === 1'b1) begin
          p6++;
          if (l6 < 0) begin l6 = n; xs6 = sum6; end
        end
        @(posedge clk); #1;
      end
      model(1, {61'd0, ea[2:0]}, {61'd0, eb[2:0]}, ms, mk);
      chk("rnd1_sum", {60'd0, xs1}, {60'd0, ms[3:0]});
      chk("rnd1_lat", 64'(l1), 64'(1 + mk));
      chk("rnd1_pulses", 64'(p1), 64'd1);
      model(6, ea, eb, ms, mk);
      chk("rnd6_sum", {45'd0, xs6}, {45'd0, ms[18:0]});
      chk("rnd6_lat", 64'(l6), 64'(6 + mk));
      chk("rnd6_pulses", 64'(p6), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
